// File: rtl/interp_sweep_feeder_pkg.sv
// Shared definitions for the sweep feeder: default code width, FSM encoding
// and the effective-step rule used when a sweep is armed.
package interp_sweep_feeder_pkg;

    localparam int XW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweepStateT;

    // A zero step would stall the sweep on one code forever, so it advances by one instead.
    function automatic int unsigned stepEffOf(input int unsigned step);
        return (step == 0) ? 1 : step;
    endfunction

endpackage

// File: rtl/interp_sweep_feeder_sweep_next_x.sv
// Next-code computation for the sweep: one extra bit of headroom so a step
// that would pass the top of the code range is seen as overshooting stop.
module sweep_next_x
    import interp_sweep_feeder_pkg::*;
#(
    parameter int XW = XW_DEF
) (
    input  logic [XW-1:0] xCur,
    input  logic [XW-1:0] stepEff,
    input  logic [XW-1:0] stopL,
    output logic [XW-1:0] nextCode,
    output logic          last
);

    logic [XW:0] nx;

    assign nx       = {1'b0, xCur} + {1'b0, stepEff};
    assign nextCode = nx[XW-1:0];
    assign last     = nx > {1'b0, stopL};

endmodule

// File: rtl/interp_sweep_feeder.sv
// Sweep generator feeding x codes to the LUT interpolator over valid/ready and
// accumulating the returned y values into a checksum and sample count.
module interp_sweep_feeder
    import interp_sweep_feeder_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int SUM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [XW-1:0]    cfg_start,
    input  logic [XW-1:0]    cfg_stop,
    input  logic [XW-1:0]    cfg_step,
    input  logic             cfg_loop,
    output logic [XW-1:0]    x_out,
    output logic             x_valid,
    input  logic             x_ready,
    input  logic [XW-1:0]    y_in,
    output logic [SUM_W-1:0] y_sum,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy,
    output logic             done
);

    sweepStateT state, stateNext;

    logic [XW-1:0]    startL;
    logic [XW-1:0]    stopL;
    logic [XW-1:0]    stepL;
    logic             loopL;
    logic [XW-1:0]    xReg;
    logic [SUM_W-1:0] sumReg;
    logic [CNT_W-1:0] cntReg;

    logic          accept;
    logic          handshake;
    logic [XW-1:0] nextCode;
    logic          last;

    // abort outranks both a new start and a same-cycle handshake.
    assign accept    = (state == ST_IDLE) && start && !abort;
    assign handshake = (state == ST_RUN) && x_ready && !abort;

    sweep_next_x #(.XW(XW)) u_next (
        .xCur     (xReg),
        .stepEff  (stepL),
        .stopL    (stopL),
        .nextCode (nextCode),
        .last     (last)
    );

    // NOTE: non-blocking assignments let every register update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: the default is assigned first so no path through the case can infer a latch.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (accept) stateNext = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    stateNext = ST_IDLE;
                end else if (handshake && last && !loopL) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startL <= '0;
            stopL  <= '0;
            stepL  <= '0;
            loopL  <= 1'b0;
            xReg   <= '0;
            sumReg <= '0;
            cntReg <= '0;
        end else if (accept) begin
            startL <= cfg_start;
            stopL  <= cfg_stop;
            stepL  <= XW'(stepEffOf(32'(cfg_step)));
            loopL  <= cfg_loop;
            xReg   <= cfg_start;
            sumReg <= '0;
            cntReg <= '0;
        end else if (handshake) begin
            sumReg <= sumReg + SUM_W'(y_in);
            cntReg <= cntReg + CNT_W'(1);
            // On the final code a one-shot sweep leaves x_out on the last value emitted.
            if (!last) begin
                xReg <= nextCode;
            end else if (loopL) begin
                xReg <= startL;
            end
        end
    end

    assign x_out      = xReg;
    assign x_valid    = (state == ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign y_sum      = sumReg;
    assign sample_cnt = cntReg;

endmodule

// File: tb/tb_interp_sweep_feeder.sv
// Self-checking bench for interp_sweep_feeder: randomized handshakes and y data
// checked against a code-list model built from start/stop/step arithmetic.
module tb_interp_sweep_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_start = '0;
    logic [7:0]  cfg_stop = '0;
    logic [7:0]  cfg_step = '0;
    logic        cfg_loop = 1'b0;
    logic [7:0]  x_out;
    logic        x_valid;
    logic        x_ready = 1'b0;
    logic [7:0]  y_in = '0;
    logic [15:0] y_sum;
    logic [15:0] sample_cnt;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int expCodes[$];

    interp_sweep_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_step   (cfg_step),
        .cfg_loop   (cfg_loop),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .y_in       (y_in),
        .y_sum      (y_sum),
        .sample_cnt (sample_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Codes a one-shot sweep emits: start first, then every start+k*step not above stop.
    task automatic buildCodes(input int s, input int e, input int st);
        int v;
        expCodes.delete();
        if (st == 0) st = 1;
        v = s;
        do begin
            expCodes.push_back(v);
            v += st;
        end while (v <= e);
    endtask

    task automatic runSweep(input string name, input int s, input int e, input int st,
                            input int readyPct, input bit randY, input bit disturb,
                            output int sumOut);
        int  idx;
        int  modelSum;
        int  cycle;
        int  lastHs;
        bit  doneSeen;
        bit  stalled;
        logic [7:0] prevX;
        @(negedge clk);
        cfg_start = 8'(s); cfg_stop = 8'(e); cfg_step = 8'(st); cfg_loop = 1'b0;
        start = 1'b1; x_ready = 1'b0; y_in = '0;
        buildCodes(s, e, st);
        idx = 0; modelSum = 0; cycle = 0; lastHs = -10; doneSeen = 0; stalled = 0; prevX = '0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (x_valid !== 1'b1 || sample_cnt !== 16'd0 || y_sum !== 16'd0) begin
            failures++;
            $display("FAIL %s start_latency: valid=%b cnt=%0d sum=%0d, required valid=1 cnt=0 sum=0",
                     name, x_valid, sample_cnt, y_sum);
        end
        while (!doneSeen && cycle < 4000) begin
            if (done === 1'b1) begin
                doneSeen = 1;
                start = 1'b0;
                checks++;
                if (idx != expCodes.size() || lastHs != cycle - 1 || x_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_timing: codes=%0d lastHs=%0d cycle=%0d valid=%b, required codes=%0d lastHs=cycle-1 valid=0",
                             name, idx, lastHs, cycle, x_valid, expCodes.size());
                end
                checks++;
                if (sample_cnt !== 16'(expCodes.size()) || y_sum !== 16'(modelSum)) begin
                    failures++;
                    $display("FAIL %s done_totals: cnt=%0d sum=%0d, required cnt=%0d sum=%0d",
                             name, sample_cnt, y_sum, expCodes.size(), 16'(modelSum));
                end
            end else begin
                checks++;
                if (x_valid !== 1'b1 || (stalled && x_out !== prevX)) begin
                    failures++;
                    $display("FAIL %s run_valid_stable: valid=%b x=%0d, required valid=1 x=%0d when stalled=%0d",
                             name, x_valid, x_out, prevX, stalled);
                end
                x_ready = (($urandom % 100) < readyPct);
                y_in = randY ? 8'($urandom) : x_out;
                if (x_valid && x_ready) begin
                    checks++;
                    if (idx >= expCodes.size() || x_out !== 8'(expCodes[idx])) begin
                        failures++;
                        $display("FAIL %s code[%0d]: x=%0d, required %0d (list size %0d)",
                                 name, idx, x_out, (idx < expCodes.size()) ? expCodes[idx] : -1,
                                 expCodes.size());
                    end
                    modelSum += y_in;
                    idx++;
                    lastHs = cycle;
                    stalled = 0;
                end else begin
                    stalled = x_valid;
                    prevX = x_out;
                end
                if (disturb) begin
                    start = 1'($urandom);
                    cfg_start = 8'($urandom); cfg_stop = 8'($urandom);
                    cfg_step = 8'($urandom); cfg_loop = 1'($urandom);
                end
            end
            @(negedge clk);
            cycle++;
        end
        start = 1'b0;
        x_ready = 1'b0;
        checks++;
        if (!doneSeen) begin
            failures++;
            $display("FAIL %s timeout: no done after %0d cycles, codes seen %0d", name, cycle, idx);
        end else if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0 || sample_cnt !== 16'(expCodes.size())) begin
            failures++;
            $display("FAIL %s after_done: busy=%b done=%b valid=%b cnt=%0d, required 0 0 0 cnt=%0d",
                     name, busy, done, x_valid, sample_cnt, expCodes.size());
        end
        sumOut = modelSum;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom); abort = 1'($urandom); cfg_start = 8'($urandom);
            cfg_stop = 8'($urandom); cfg_step = 8'($urandom); cfg_loop = 1'($urandom);
            x_ready = 1'($urandom); y_in = 8'($urandom);
            #1;
            checks++;
            if ({x_out, x_valid, y_sum, sample_cnt, busy, done} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: x=%0d valid=%b sum=%0d cnt=%0d busy=%b done=%b, required all 0",
                         x_out, x_valid, y_sum, sample_cnt, busy, done);
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; x_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b valid=%b done=%b, required 0 0 0", busy, x_valid, done);
        end
    endtask

    task automatic test_full_sweep();
        int s;
        runSweep("full_sweep", 0, 255, 1, 100, 0, 0, s);
        checks++;
        if (y_sum !== 16'd32640 || sample_cnt !== 16'd256) begin
            failures++;
            $display("FAIL full_sweep_totals: sum=%0d cnt=%0d, required 32640 256", y_sum, sample_cnt);
        end
    endtask

    task automatic test_step_overshoot();
        int s;
        runSweep("overshoot", 10, 20, 4, 100, 1, 0, s);
        checks++;
        if (sample_cnt !== 16'd3) begin
            failures++;
            $display("FAIL overshoot_count: cnt=%0d, required 3", sample_cnt);
        end
        runSweep("step_zero", 10, 20, 0, 100, 1, 0, s);
        checks++;
        if (sample_cnt !== 16'd11) begin
            failures++;
            $display("FAIL step_zero_count: cnt=%0d, required 11", sample_cnt);
        end
    endtask

    task automatic test_backpressure();
        int s;
        runSweep("backpressure", 0, 255, 1, 50, 0, 0, s);
        checks++;
        if (y_sum !== 16'd32640 || sample_cnt !== 16'd256) begin
            failures++;
            $display("FAIL backpressure_totals: sum=%0d cnt=%0d, required 32640 256", y_sum, sample_cnt);
        end
    endtask

    task automatic test_random_sweeps();
        int s;
        for (int i = 0; i < 4; i++) begin
            runSweep("random_sweep", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 16)), int'($urandom_range(30, 100)), 1, 0, s);
        end
    endtask

    task automatic test_loop_abort();
        int period[3] = '{250, 252, 254};
        int hs = 0;
        int modelSum = 0;
        int cycle = 0;
        @(negedge clk);
        cfg_start = 8'd250; cfg_stop = 8'd255; cfg_step = 8'd2; cfg_loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (hs < 10 && cycle < 500) begin
            checks++;
            if (x_valid !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL loop_valid: valid=%b done=%b, required 1 0", x_valid, done);
            end
            x_ready = (($urandom % 100) < 70);
            y_in = 8'($urandom);
            if (x_valid && x_ready) begin
                checks++;
                if (x_out !== 8'(period[hs % 3])) begin
                    failures++;
                    $display("FAIL loop_code[%0d]: x=%0d, required %0d", hs, x_out, period[hs % 3]);
                end
                modelSum += y_in;
                hs++;
            end
            @(negedge clk);
            cycle++;
        end
        checks++;
        if (hs < 10) begin
            failures++;
            $display("FAIL loop_timeout: handshakes=%0d, required 10", hs);
        end
        x_ready = 1'b1; abort = 1'b1; y_in = 8'hFF;
        @(negedge clk);
        abort = 1'b0; x_ready = 1'b0;
        checks++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sample_cnt !== 16'(hs) || y_sum !== 16'(modelSum)) begin
            failures++;
            $display("FAIL abort_result: valid=%b busy=%b done=%b cnt=%0d sum=%0d, required 0 0 0 cnt=%0d sum=%0d",
                     x_valid, busy, done, sample_cnt, y_sum, hs, 16'(modelSum));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sample_cnt !== 16'(hs)) begin
            failures++;
            $display("FAIL abort_no_done: done=%b cnt=%0d, required 0 %0d", done, sample_cnt, hs);
        end
    endtask

    task automatic test_edge_cases();
        int s;
        runSweep("start_gt_stop", 200, 100, 5, 100, 1, 0, s);
        checks++;
        if (sample_cnt !== 16'd1) begin
            failures++;
            $display("FAIL start_gt_stop_count: cnt=%0d, required 1", sample_cnt);
        end
        runSweep("start_while_busy", 10, 40, 3, 60, 1, 1, s);
        checks++;
        if (sample_cnt !== 16'd11) begin
            failures++;
            $display("FAIL start_while_busy_count: cnt=%0d, required 11", sample_cnt);
        end
        // Asynchronous reset in the middle of a sweep, between clock edges.
        @(negedge clk);
        cfg_start = 8'd0; cfg_stop = 8'd255; cfg_step = 8'd3; cfg_loop = 1'b0; start = 1'b1;
        x_ready = 1'b1; y_in = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({x_out, x_valid, y_sum, sample_cnt, busy, done} !== '0) begin
            failures++;
            $display("FAIL async_reset: x=%0d valid=%b sum=%0d cnt=%0d busy=%b done=%b, required all 0",
                     x_out, x_valid, y_sum, sample_cnt, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1; x_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_release: busy=%b done=%b valid=%b, required 0 0 0", busy, done, x_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_step_overshoot();
        test_backpressure();
        test_random_sweeps();
        test_loop_abort();
        test_edge_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
